// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: turns MemRead/MemWrite into a req/ack bus access and returns extended load data.
// Latency: 3 cycles (IDLE -> REQ -> DONE) when mem_ack arrives in the first REQ cycle; stall is high for 2 of them.
// Backpressure: stall freezes upstream until the access completes or times out; errored accesses never stall.
module mem_access_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        ld_valid,
  output logic        misalign,
  output logic        illegal,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t      state, state_nxt;
  logic [7:0]  cnt;
  logic [2:0]  f3_q;       // size/sign of the access in flight
  logic [1:0]  off_q;      // byte offset of the access in flight
  logic        is_load_q;
  logic        to_q;       // access in flight ended by timeout

  logic        access;
  logic        legal_f3;
  logic        aligned;
  logic        start;
  logic        time_up;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] ext_c;

  assign access  = MemRead | MemWrite;
  // Last REQ cycle before the access is declared dead.
  assign time_up = (cnt == 8'(TIMEOUT - 1));

  // Decode legality of the control/funct3 combination; loads accept the unsigned variants, stores do not.
  always_comb begin
    legal_f3 = 1'b0;
    if (MemRead && MemWrite) begin
      legal_f3 = 1'b0;
    end else if (MemRead) begin
      case (funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal_f3 = 1'b1;
        default:                                legal_f3 = 1'b0;
      endcase
    end else begin
      case (funct3)
        3'b000, 3'b001, 3'b010: legal_f3 = 1'b1;
        default:                legal_f3 = 1'b0;
      endcase
    end
  end

  // Natural alignment check on the access size (funct3[1:0]).
  always_comb begin
    aligned = 1'b0;
    case (funct3[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~addr[0];
      2'b10:   aligned = (addr[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
  end

  // Byte enables and lane-replicated store data for the bus.
  always_comb begin
    be_c    = 4'b1111;
    wdata_c = wdata;
    case (funct3[1:0])
      2'b00: begin
        be_c    = 4'b0001 << addr[1:0];
        wdata_c = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_c    = 4'b0011 << {addr[1], 1'b0};
        wdata_c = {2{wdata[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = wdata;
      end
    endcase
  end

  // Pick the addressed byte/half from the read word and extend it per the latched funct3.
  always_comb begin
    rd_byte = 8'(mem_rdata >> {off_q, 3'b000});
    rd_half = 16'(mem_rdata >> {off_q[1], 4'b0000});
    ext_c   = mem_rdata;
    case (f3_q)
      3'b000:  ext_c = {{24{rd_byte[7]}}, rd_byte};
      3'b100:  ext_c = {24'b0, rd_byte};
      3'b001:  ext_c = {{16{rd_half[15]}}, rd_half};
      3'b101:  ext_c = {16'b0, rd_half};
      default: ext_c = mem_rdata;
    endcase
  end

  // Next-state and combinational outputs: errors and the launch stall come straight from IDLE inputs.
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    misalign  = 1'b0;
    illegal   = 1'b0;
    start     = 1'b0;
    ld_valid  = 1'b0;
    bus_err   = 1'b0;
    case (state)
      IDLE: begin
        if (access) begin
          if (!legal_f3) begin
            illegal = 1'b1;
          end else if (!aligned) begin
            misalign = 1'b1;
          end else begin
            stall     = 1'b1;
            start     = 1'b1;
            state_nxt = REQ;
          end
        end
      end
      REQ: begin
        stall = 1'b1;
        if (mem_ack || time_up) state_nxt = DONE;
      end
      DONE: begin
        // Inputs still show the completing instruction here; they are deliberately ignored.
        ld_valid  = is_load_q & ~to_q;
        bus_err   = to_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Cycles spent waiting in REQ; cleared whenever no access is waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                cnt <= 8'd0;
    else if (state == REQ)  cnt <= cnt + 8'd1;
    else                    cnt <= 8'd0;
  end

  // Registered bus outputs: loaded at launch, request dropped on ack or timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_be    <= 4'd0;
      mem_wdata <= 32'd0;
    end else if (start) begin
      mem_req   <= 1'b1;
      mem_we    <= MemWrite;
      mem_addr  <= {addr[31:2], 2'b00};
      mem_be    <= be_c;
      mem_wdata <= wdata_c;
    end else if ((state == REQ) && (mem_ack || time_up)) begin
      mem_req   <= 1'b0;
    end
  end

  // Remember what the in-flight access needs for extraction and completion reporting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f3_q      <= 3'd0;
      off_q     <= 2'd0;
      is_load_q <= 1'b0;
      to_q      <= 1'b0;
    end else if (start) begin
      f3_q      <= funct3;
      off_q     <= addr[1:0];
      is_load_q <= MemRead;
      to_q      <= 1'b0;
    end else if ((state == REQ) && !mem_ack && time_up) begin
      to_q      <= 1'b1;
    end
  end

  // Load result: extended read data on ack, zero when the access times out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_data <= 32'd0;
    end else if (state == REQ) begin
      if (mem_ack) begin
        if (is_load_q) load_data <= ext_c;
      end else if (time_up) begin
        load_data <= 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead, MemWrite;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        stall;
  logic [31:0] load_data;
  logic        ld_valid, misalign, illegal, bus_err;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite), .funct3(funct3),
    .addr(addr), .wdata(wdata), .stall(stall), .load_data(load_data), .ld_valid(ld_valid),
    .misalign(misalign), .illegal(illegal), .bus_err(bus_err), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef enum int {K_OK, K_MIS, K_ILL} kind_t;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    int          dly;     // REQ cycle index carrying the ack; >= TO means no ack in time
    logic [31:0] rdata;
    kind_t       kind;
    logic [3:0]  be;
    logic [31:0] mwd;
    logic [31:0] ld;
    logic        to;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: derive the expected outcome from the access rules using plain arithmetic.
  function automatic vec_t model(input vec_t v);
    vec_t        e;
    int          nb, off;
    logic [31:0] sh;
    bit          ld_ok, st_ok;
    e     = v;
    ld_ok = (v.f3 == 3'd0) || (v.f3 == 3'd1) || (v.f3 == 3'd2) || (v.f3 == 3'd4) || (v.f3 == 3'd5);
    st_ok = (v.f3 <= 3'd2);
    nb    = 1 << v.f3[1:0];
    off   = int'(v.addr % 32'd4);
    e.to  = (v.dly >= TO);
    if ((v.rd && v.wr) || (v.rd && !ld_ok) || (v.wr && !st_ok)) e.kind = K_ILL;
    else if ((off % nb) != 0)                                    e.kind = K_MIS;
    else                                                         e.kind = K_OK;
    e.be  = (nb <= 4) ? 4'(((1 << nb) - 1) << off) : 4'd0;
    if (nb == 1)      e.mwd = {24'd0, v.wd[7:0]} * 32'h01010101;
    else if (nb == 2) e.mwd = {16'd0, v.wd[15:0]} * 32'h00010001;
    else              e.mwd = v.wd;
    sh = v.rdata >> (8 * off);
    if (nb == 1) begin
      e.ld = sh & 32'hFF;
      if (v.f3 == 3'd0 && sh[7]) e.ld = e.ld | 32'hFFFFFF00;
    end else if (nb == 2) begin
      e.ld = sh & 32'hFFFF;
      if (v.f3 == 3'd1 && sh[15]) e.ld = e.ld | 32'hFFFF0000;
    end else begin
      e.ld = v.rdata;
    end
    if (e.to || !v.rd) e.ld = 32'd0;
    return e;
  endfunction

  // Drive one access starting just after a rising edge, ending just after a rising edge back in IDLE.
  task automatic run(input vec_t v, input string tag);
    int n;
    int drops;
    bit done;
    MemRead = v.rd; MemWrite = v.wr; funct3 = v.f3; addr = v.addr; wdata = v.wd;
    @(negedge clk);
    check({tag, " illegal"},  32'(illegal),  32'(v.kind == K_ILL));
    check({tag, " misalign"}, 32'(misalign), 32'(v.kind == K_MIS));
    check({tag, " stall0"},   32'(stall),    32'(v.kind == K_OK));
    if (v.kind != K_OK) begin
      @(posedge clk); #1;
      MemRead = 0; MemWrite = 0;
      @(negedge clk);
      check({tag, " no req"}, 32'(mem_req), 32'd0);
      @(posedge clk); #1;
      return;
    end
    @(posedge clk); #1;
    check({tag, " req"},  32'(mem_req), 32'd1);
    check({tag, " we"},   32'(mem_we),  32'(v.wr));
    check({tag, " addr"}, mem_addr,     v.addr & 32'hFFFFFFFC);
    check({tag, " be"},   32'(mem_be),  32'(v.be));
    if (v.wr) check({tag, " wdata"}, mem_wdata, v.mwd);
    n = 0; drops = 0; done = 0;
    for (int k = 0; k < TO + 3 && !done; k++) begin
      mem_ack   = (n == v.dly);
      mem_rdata = (n == v.dly) ? v.rdata : $urandom;
      @(negedge clk);
      if (!stall) begin
        done = 1;
      end else begin
        if (!mem_req) drops++;
        n++;
        @(posedge clk); #1;
      end
    end
    check({tag, " completed"}, 32'(done), 32'd1);
    check({tag, " req cycles"}, n, v.to ? TO : v.dly + 1);
    check({tag, " req held"}, drops, 0);
    check({tag, " ld_valid"}, 32'(ld_valid), 32'(v.rd && !v.to));
    check({tag, " bus_err"},  32'(bus_err),  32'(v.to));
    check({tag, " req drop"}, 32'(mem_req),  32'd0);
    if (v.rd) check({tag, " load_data"}, load_data, v.ld);
    @(posedge clk); #1;
    MemRead = 0; MemWrite = 0; mem_ack = 0;
    @(negedge clk);
    check({tag, " idle stall"}, 32'(stall), 32'd0);
    check({tag, " idle ldv"},   32'(ld_valid | bus_err), 32'd0);
    @(posedge clk); #1;
  endtask

  vec_t tbl [13];
  vec_t v;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; MemRead = 0; MemWrite = 0; funct3 = 0; addr = 0; wdata = 0;
    mem_ack = 0; mem_rdata = 0;

    //            rd wr f3    addr          wd            dly rdata         kind   be      mwd           ld            to
    tbl[0]  = '{1, 0, 3'd2, 32'h100, 32'h0,        0, 32'hDEADBEEF, K_OK,  4'hF, 32'h0,        32'hDEADBEEF, 0};
    tbl[1]  = '{1, 0, 3'd0, 32'h203, 32'h0,        0, 32'h80FF7F01, K_OK,  4'h8, 32'h0,        32'hFFFFFF80, 0};
    tbl[2]  = '{1, 0, 3'd4, 32'h203, 32'h0,        0, 32'h80FF7F01, K_OK,  4'h8, 32'h0,        32'h00000080, 0};
    tbl[3]  = '{0, 1, 3'd1, 32'h302, 32'h1234ABCD, 0, 32'h0,        K_OK,  4'hC, 32'hABCDABCD, 32'h0,        0};
    tbl[4]  = '{1, 0, 3'd2, 32'h101, 32'h0,        0, 32'h0,        K_MIS, 4'h0, 32'h0,        32'h0,        0};
    tbl[5]  = '{1, 1, 3'd2, 32'h100, 32'h0,        0, 32'h0,        K_ILL, 4'h0, 32'h0,        32'h0,        0};
    tbl[6]  = '{1, 0, 3'd2, 32'h104, 32'h0,        9, 32'h0,        K_OK,  4'hF, 32'h0,        32'h0,        1};
    tbl[7]  = '{1, 0, 3'd1, 32'h202, 32'h0,        1, 32'h80FF7F01, K_OK,  4'hC, 32'h0,        32'hFFFF80FF, 0};
    tbl[8]  = '{1, 0, 3'd5, 32'h200, 32'h0,        2, 32'h80FF7F01, K_OK,  4'h3, 32'h0,        32'h00007F01, 0};
    tbl[9]  = '{0, 1, 3'd0, 32'h001, 32'h000000A5, 0, 32'h0,        K_OK,  4'h2, 32'hA5A5A5A5, 32'h0,        0};
    tbl[10] = '{0, 1, 3'd2, 32'h010, 32'hCAFEF00D, 3, 32'h0,        K_OK,  4'hF, 32'hCAFEF00D, 32'h0,        0};
    tbl[11] = '{0, 1, 3'd4, 32'h010, 32'h0,        0, 32'h0,        K_ILL, 4'h0, 32'h0,        32'h0,        0};
    tbl[12] = '{1, 0, 3'd1, 32'h203, 32'h0,        0, 32'h0,        K_MIS, 4'h0, 32'h0,        32'h0,        0};

    // Reset values.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst stall",     32'(stall),     32'd0);
    check("rst mem_req",   32'(mem_req),   32'd0);
    check("rst mem_we",    32'(mem_we),    32'd0);
    check("rst mem_addr",  mem_addr,       32'd0);
    check("rst mem_be",    32'(mem_be),    32'd0);
    check("rst mem_wdata", mem_wdata,      32'd0);
    check("rst load_data", load_data,      32'd0);
    check("rst pulses",    32'({ld_valid, misalign, illegal, bus_err}), 32'd0);
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) run(tbl[i], $sformatf("tbl%0d", i));

    // Stray ack while idle must not start or complete anything.
    mem_ack = 1; mem_rdata = 32'h55AA55AA;
    @(negedge clk);
    check("idle ack ldv", 32'(ld_valid), 32'd0);
    @(posedge clk); #1;
    mem_ack = 0;
    @(negedge clk);
    check("idle ack req", 32'(mem_req), 32'd0);
    @(posedge clk); #1;

    // Reset in the middle of a request abandons it silently.
    MemRead = 1; funct3 = 3'd2; addr = 32'h40;
    @(posedge clk); #1;
    @(negedge clk);
    check("midrst req before", 32'(mem_req), 32'd1);
    #2;
    rst = 1; MemRead = 0;
    #1;
    check("midrst req drop", 32'(mem_req), 32'd0);
    check("midrst stall",    32'(stall),   32'd0);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    check("midrst no err", 32'({bus_err, ld_valid, mem_req}), 32'd0);
    @(posedge clk); #1;
    v = '{0, 1, 3'd2, 32'h0, 32'h600DF00D, 0, 32'h0, K_OK, 4'h0, 32'h0, 32'h0, 0};
    run(model(v), "post-rst sw");

    // Randomized accesses against the reference.
    for (int i = 0; i < 150; i++) begin
      int r;
      r       = $urandom_range(0, 9);
      v.rd    = (r <= 4) || (r == 9);
      v.wr    = (r >= 5);
      v.f3    = 3'($urandom_range(0, 7));
      v.addr  = $urandom;
      v.wd    = $urandom;
      v.dly   = $urandom_range(0, 5);
      v.rdata = $urandom;
      run(model(v), $sformatf("rnd%0d", i));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
